m_seq63_checker: RTL and testbench
==================================

Name: m_seq63_checker

Overview:
- Receive-side checker for the 63-bit m-sequence (PN6) stream produced by the team's m-sequence generator.
- Self-synchronises to the incoming bit stream, then free-runs a local LFSR and compares it bit-by-bit against the received bits.
- Reports lock, per-bit errors and BER counters.
- Sits at the far end of the test link or loopback path, clocked in the same sclk domain as the bit source.

Parameters:
- POLY, 6'b101101: tap vector, same convention as the generator. Predicted bit = XOR over i of (h[i] & POLY[5-i]), where h[0] is the oldest of the last 6 bits.
- LOCK_MATCHES, 16: consecutive correct predictions needed to declare lock (range 1..255).
- WIN_LEN, 64: length of the loss-of-lock observation window, in valid bits (range 2..1023).
- UNLOCK_ERRS, 8: errors within one window that force loss of lock (range 1..WIN_LEN).

Ports:
- sclk, input, 1: system clock; all logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- din, input, 1: received sequence bit, equivalent to the generator's m_seq output.
- din_valid, input, 1: din is sampled only when this is high; low cycles are ignored completely.
- clr, input, 1: synchronous clear of bit_cnt and err_cnt; does not affect lock.
- lock, output, 1: checker is synchronised.
- err, output, 1: one-cycle pulse when a locked compare mismatches.
- lock_lost, output, 1: one-cycle pulse when the checker moves from LOCKED to SEARCH.
- bit_cnt, output, 32: number of bits compared while LOCKED, saturating.
- err_cnt, output, 32: number of errors while LOCKED, saturating.
- state, output, 2: 0 = FILL, 1 = SEARCH, 2 = LOCKED.

Behaviour:
- Reset (rst = 1 at a clock edge):
  - All outputs go to 0; state = FILL.
  - History register h = 0; fill, match, window and window-error counters = 0.
  - Reset mid-operation discards lock immediately. No pulses are generated on the reset edge.
- Sequence recurrence with the default POLY: b[n+6] = b[n] ^ b[n+2] ^ b[n+3] ^ b[n+5].
- All outputs are registered. A din sampled at edge k is reflected in lock/err/counters after edge k, visible in cycle k+1.
- FILL:
  - Each valid bit shifts into h: h[5] = din, h[4:0] = h[5:1].
  - After the 6th valid bit, move to SEARCH.
- SEARCH:
  - Each valid bit is compared with pred(h), then din is shifted into h, so the checker stays self-synchronising.
  - Match with h != 0: match counter +1.
  - Mismatch, or h == 0: match counter = 0. The h == 0 case prevents locking onto a stuck-at-0 line.
  - When the match counter reaches LOCK_MATCHES: lock = 1, state = LOCKED; window counter and window errors = 0.
  - err is never asserted in SEARCH.
- LOCKED:
  - h free-runs: the predicted bit, not din, is shifted in. One corrupted bit therefore produces exactly one err pulse.
  - Each valid bit: bit_cnt +1. On mismatch: err = 1, err_cnt +1, window errors +1.
  - Window counter increments per valid bit. On reaching WIN_LEN it wraps to 0 and window errors reset to 0.
  - If window errors reach UNLOCK_ERRS on a bit, then on that same edge: lock = 0, lock_lost = 1, state = FILL, fill counter = 0.
  - Threshold check takes priority over the window wrap when both occur on the same bit.
- Counters:
  - Both counters saturate at 32'hFFFFFFFF and hold there.
  - clr has priority over an increment on the same edge; that bit is not counted.
  - err still pulses even when clr is active.
- din_valid = 0: h, all counters and state are held; err and lock_lost are 0.

Decomposition:
- Shared package m_seq_pkg:
  - M_SEQ_LEN = 6, M_SEQ_PERIOD = 63, default POLY.
  - State encoding (FILL/SEARCH/LOCKED).
  - Function m_seq_pred(h, poly) for tap XOR, shared with the generator.
- No sub-module is required. Optional sub-module sat_cnt32: a saturating counter with clear and enable, instanced twice.

Test Plan:
1. Generator seeded 6'b100000 (bits 0,0,0,0,0,1,1,1,...), din_valid = 1 every cycle.
   -> FILL ends after bit 6; lock rises after valid bit 22; err = 0 over 10 periods; bit_cnt = 630 − 22 = 608 after 630 bits.
2. Locked, invert one bit.
   -> Exactly one err pulse; err_cnt = 1; lock stays high; next bit correct.
3. Locked, invert 8 bits within 64.
   -> lock_lost pulse on the 8th error; state = FILL; relock 22 valid bits later. With 7 errors per window, lock holds.
4. din stuck at 0 for 200 bits.
   -> Never locks; state stays SEARCH; err = 0.
5. din_valid toggled 1-0-1 on clean data.
   -> Same lock point, counted in valid bits; counters frozen in idle cycles.
6. clr asserted coincident with an error.
   -> err pulses; err_cnt = 0 after the edge. Counter preset via force to FFFFFFFF stays at FFFFFFFF on further errors. rst asserted while locked -> all outputs 0 next cycle.

Source files
------------

// File: rtl/m_seq_pkg.sv
// Shared definitions for the PN6 m-sequence generator and checker:
// sequence geometry, default tap vector, checker state encoding and tap XOR.
package m_seq_pkg;

    localparam int M_SEQ_LEN = 6;
    localparam int M_SEQ_PERIOD = 63;
    localparam logic [M_SEQ_LEN-1:0] M_SEQ_POLY = 6'b101101;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } seq_state_e;

    // h[0] is the oldest of the last M_SEQ_LEN bits; it pairs with the poly MSB.
    function automatic logic m_seq_pred(input logic [M_SEQ_LEN-1:0] h,
                                        input logic [M_SEQ_LEN-1:0] poly);
        logic p;
        p = 1'b0;
        for (int i = 0; i < M_SEQ_LEN; i++) begin
            p = p ^ (h[i] & poly[M_SEQ_LEN-1-i]);
        end
        return p;
    endfunction

endpackage

// File: rtl/sat_cnt32.sv
// 32-bit counter with synchronous clear and enable that sticks at all-ones.
module sat_cnt32 (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_en,
    output logic [31:0] o_cnt
);

    logic [31:0] r_cnt;

    // Clear wins over a same-edge increment.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/m_seq63_checker.sv
// PN6 receive checker: fills a history, self-synchronises on consecutive
// correct predictions, then free-runs and counts bit errors with windowed loss-of-lock.
module m_seq63_checker
    import m_seq_pkg::*;
#(
    parameter logic [M_SEQ_LEN-1:0] POLY = M_SEQ_POLY,
    parameter int LOCK_MATCHES = 16,
    parameter int WIN_LEN      = 64,
    parameter int UNLOCK_ERRS  = 8
) (
    input  logic        sclk,
    input  logic        rst,
    input  logic        din,
    input  logic        din_valid,
    input  logic        clr,
    output logic        lock,
    output logic        err,
    output logic        lock_lost,
    output logic [31:0] bit_cnt,
    output logic [31:0] err_cnt,
    output logic [1:0]  state
);

    localparam logic [7:0] LM_LAST  = 8'(LOCK_MATCHES - 1);
    localparam logic [9:0] WIN_LAST = 10'(WIN_LEN - 1);
    localparam logic [9:0] UE       = 10'(UNLOCK_ERRS);
    localparam logic [2:0] FILL_LAST = 3'(M_SEQ_LEN - 1);

    seq_state_e           r_state;
    logic [M_SEQ_LEN-1:0] r_h;
    logic [2:0]           r_fill;
    logic [7:0]           r_match;
    logic [9:0]           r_win;
    logic [9:0]           r_werr;
    logic                 r_lock;
    logic                 r_err;
    logic                 r_lock_lost;

    logic       w_pred;
    logic       w_mis;
    logic [9:0] w_werr_nx;
    logic       w_cnt_en;

    assign w_pred    = m_seq_pred(r_h, POLY);
    assign w_mis     = din ^ w_pred;
    assign w_werr_nx = r_werr + {9'd0, w_mis};
    assign w_cnt_en  = din_valid && (r_state == ST_LOCKED);

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_state     <= ST_FILL;
            r_h         <= '0;
            r_fill      <= '0;
            r_match     <= '0;
            r_win       <= '0;
            r_werr      <= '0;
            r_lock      <= 1'b0;
            r_err       <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_err       <= 1'b0;
            r_lock_lost <= 1'b0;
            if (din_valid) begin
                case (r_state)
                    ST_FILL: begin
                        r_h <= {din, r_h[M_SEQ_LEN-1:1]};
                        if (r_fill == FILL_LAST) begin
                            r_fill  <= '0;
                            r_match <= '0;
                            r_state <= ST_SEARCH;
                        end else begin
                            r_fill <= r_fill + 3'd1;
                        end
                    end
                    ST_SEARCH: begin
                        // All-zero history would "predict" a dead line forever.
                        r_h <= {din, r_h[M_SEQ_LEN-1:1]};
                        if (w_mis || (r_h == '0)) begin
                            r_match <= '0;
                        end else if (r_match == LM_LAST) begin
                            r_match <= '0;
                            r_lock  <= 1'b1;
                            r_state <= ST_LOCKED;
                            r_win   <= '0;
                            r_werr  <= '0;
                        end else begin
                            r_match <= r_match + 8'd1;
                        end
                    end
                    ST_LOCKED: begin
                        // Free-run on the prediction so a flipped bit costs exactly one err.
                        r_h   <= {w_pred, r_h[M_SEQ_LEN-1:1]};
                        r_err <= w_mis;
                        if (w_mis && (w_werr_nx == UE)) begin
                            r_lock      <= 1'b0;
                            r_lock_lost <= 1'b1;
                            r_state     <= ST_FILL;
                            r_fill      <= '0;
                        end else if (r_win == WIN_LAST) begin
                            r_win  <= '0;
                            r_werr <= '0;
                        end else begin
                            r_win  <= r_win + 10'd1;
                            r_werr <= w_werr_nx;
                        end
                    end
                    default: r_state <= ST_FILL;
                endcase
            end
        end
    end

    sat_cnt32 u_bit_cnt (
        .i_clk (sclk),
        .i_rst (rst),
        .i_clr (clr),
        .i_en  (w_cnt_en),
        .o_cnt (bit_cnt)
    );

    sat_cnt32 u_err_cnt (
        .i_clk (sclk),
        .i_rst (rst),
        .i_clr (clr),
        .i_en  (w_cnt_en && w_mis),
        .o_cnt (err_cnt)
    );

    assign lock      = r_lock;
    assign err       = r_err;
    assign lock_lost = r_lock_lost;
    assign state     = r_state;

endmodule

// File: tb/tb_m_seq63_checker.sv
// Scoreboard bench for m_seq63_checker: stimulus queues checkpoint expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_m_seq63_checker;
    import m_seq_pkg::*;

    localparam int M_LK = 1, M_ER = 2, M_LL = 4, M_ST = 8, M_BC = 16, M_EC = 32, M_ALL = 63;

    logic        sclk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        clr = 1'b0;
    logic        lock, err, lock_lost;
    logic [31:0] bit_cnt, err_cnt;
    logic [1:0]  state;

    m_seq63_checker dut (
        .sclk      (sclk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .clr       (clr),
        .lock      (lock),
        .err       (err),
        .lock_lost (lock_lost),
        .bit_cnt   (bit_cnt),
        .err_cnt   (err_cnt),
        .state     (state)
    );

    always #5 sclk = ~sclk;

    typedef struct {
        string       name;
        int          tgt;
        int          mask;
        logic        lk;
        logic        er;
        logic        ll;
        logic [1:0]  st;
        logic [31:0] bc;
        logic [31:0] ec;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic seq [M_SEQ_PERIOD];
    int   gp = 0;

    always @(posedge sclk) cyc <= cyc + 1;

    // Monitor: every expectation targets the cycle right after its driving edge.
    always @(negedge sclk) begin
        exp_t e;
        logic bad;
        while (sbq.size() > 0 && sbq[0].tgt <= cyc) begin
            e = sbq.pop_front();
            n_tests++;
            bad = (e.tgt != cyc);
            if ((e.mask & M_LK) != 0 && lock !== e.lk) bad = 1'b1;
            if ((e.mask & M_ER) != 0 && err !== e.er) bad = 1'b1;
            if ((e.mask & M_LL) != 0 && lock_lost !== e.ll) bad = 1'b1;
            if ((e.mask & M_ST) != 0 && state !== e.st) bad = 1'b1;
            if ((e.mask & M_BC) != 0 && bit_cnt !== e.bc) bad = 1'b1;
            if ((e.mask & M_EC) != 0 && err_cnt !== e.ec) bad = 1'b1;
            if (bad) begin
                n_fail++;
                $display("FAIL %s cyc=%0d tgt=%0d got lock=%b err=%b lost=%b state=%0d bit_cnt=%h err_cnt=%h expected lock=%b err=%b lost=%b state=%0d bit_cnt=%h err_cnt=%h (mask %0d)",
                         e.name, cyc, e.tgt, lock, err, lock_lost, state, bit_cnt, err_cnt,
                         e.lk, e.er, e.ll, e.st, e.bc, e.ec, e.mask);
            end
        end
    end

    task automatic drive(input logic b, input logic v, input logic c, input logic r);
        @(negedge sclk);
        din = b;
        din_valid = v;
        clr = c;
        rst = r;
    endtask

    task automatic chk(input string nm, input int m, input logic lk, input logic er,
                       input logic ll, input logic [1:0] st, input logic [31:0] bc,
                       input logic [31:0] ec);
        exp_t e;
        e.name = nm; e.tgt = cyc + 1; e.mask = m;
        e.lk = lk; e.er = er; e.ll = ll; e.st = st; e.bc = bc; e.ec = ec;
        sbq.push_back(e);
    endtask

    task automatic next_bit(output logic b);
        b = seq[gp % M_SEQ_PERIOD];
        gp++;
    endtask

    initial begin
        logic b;
        logic e;
        logic [1:0] st_exp;
        int bc_exp;

        for (int n = 0; n < M_SEQ_PERIOD; n++) begin
            if (n < 5) seq[n] = 1'b0;
            else if (n == 5) seq[n] = 1'b1;
            else seq[n] = seq[n-6] ^ seq[n-4] ^ seq[n-3] ^ seq[n-1];
        end

        // Reset with valid data present must still leave everything at zero.
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        chk("reset", M_ALL, 1'b0, 1'b0, 1'b0, ST_FILL, 0, 0);

        // Clean stream: lock after valid bit 22, 630 bits total.
        gp = 0;
        for (int i = 1; i <= 630; i++) begin
            next_bit(b);
            drive(b, 1'b1, 1'b0, 1'b0);
            if (i == 5)  chk("t1_fill5", M_ST | M_LK, 1'b0, 1'b0, 1'b0, ST_FILL, 0, 0);
            if (i == 6)  chk("t1_search6", M_ST | M_LK, 1'b0, 1'b0, 1'b0, ST_SEARCH, 0, 0);
            if (i == 21) chk("t1_nolock21", M_ST | M_LK, 1'b0, 1'b0, 1'b0, ST_SEARCH, 0, 0);
            if (i == 22) chk("t1_lock22", M_ALL, 1'b1, 1'b0, 1'b0, ST_LOCKED, 0, 0);
            if (i > 22)  chk("t1_clean", M_LK | M_ER | M_LL, 1'b1, 1'b0, 1'b0, ST_LOCKED, 0, 0);
            if (i == 630) chk("t1_cnt630", M_BC | M_EC, 1'b1, 1'b0, 1'b0, ST_LOCKED, 608, 0);
        end

        // Single inverted bit: one err pulse, next bit clean.
        next_bit(b);
        drive(~b, 1'b1, 1'b0, 1'b0);
        chk("t2_err", M_ALL, 1'b1, 1'b1, 1'b0, ST_LOCKED, 609, 1);
        next_bit(b);
        drive(b, 1'b1, 1'b0, 1'b0);
        chk("t2_next", M_ALL, 1'b1, 1'b0, 1'b0, ST_LOCKED, 610, 1);

        // Pad to a window boundary (34 of 64 used), then 7 errors in one window.
        for (int i = 0; i < 30; i++) begin
            next_bit(b);
            drive(b, 1'b1, 1'b0, 1'b0);
        end
        chk("t3_pad", M_ALL, 1'b1, 1'b0, 1'b0, ST_LOCKED, 640, 1);
        for (int i = 0; i < 64; i++) begin
            e = (i % 8 == 0) && (i < 56);
            next_bit(b);
            drive(b ^ e, 1'b1, 1'b0, 1'b0);
            chk("t3_seven", M_LK | M_ER | M_LL, 1'b1, e, 1'b0, ST_LOCKED, 0, 0);
        end
        chk("t3_seven_end", M_ALL, 1'b1, 1'b0, 1'b0, ST_LOCKED, 704, 8);

        // Eight errors in the next window: lose lock on the eighth.
        for (int i = 0; i < 15; i++) begin
            e = (i % 2 == 0);
            next_bit(b);
            drive(b ^ e, 1'b1, 1'b0, 1'b0);
            if (i < 14) chk("t3_eight", M_LK | M_ER | M_LL | M_ST, 1'b1, e, 1'b0, ST_LOCKED, 0, 0);
            else        chk("t3_lost", M_ALL, 1'b0, 1'b1, 1'b1, ST_FILL, 719, 16);
        end
        for (int j = 1; j <= 22; j++) begin
            next_bit(b);
            drive(b, 1'b1, 1'b0, 1'b0);
            if (j == 1)  chk("t3_lost_pulse", M_LK | M_ER | M_LL | M_ST, 1'b0, 1'b0, 1'b0, ST_FILL, 0, 0);
            if (j == 6)  chk("t3_research", M_LK | M_ST, 1'b0, 1'b0, 1'b0, ST_SEARCH, 0, 0);
            if (j == 21) chk("t3_relock21", M_LK | M_ST, 1'b0, 1'b0, 1'b0, ST_SEARCH, 0, 0);
            if (j == 22) chk("t3_relock22", M_ALL, 1'b1, 1'b0, 1'b0, ST_LOCKED, 719, 16);
        end

        // Stuck-at-0 line must never lock.
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        chk("t4_reset", M_ALL, 1'b0, 1'b0, 1'b0, ST_FILL, 0, 0);
        for (int i = 1; i <= 200; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            chk("t4_nolock", M_LK | M_ER | M_LL, 1'b0, 1'b0, 1'b0, ST_FILL, 0, 0);
            if (i == 6 || i == 200) chk("t4_search", M_ST, 1'b0, 1'b0, 1'b0, ST_SEARCH, 0, 0);
        end

        // Valid/idle alternation: lock point counted in valid bits only.
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        chk("t5_reset", M_ALL, 1'b0, 1'b0, 1'b0, ST_FILL, 0, 0);
        gp = 0;
        for (int k = 1; k <= 32; k++) begin
            next_bit(b);
            st_exp = (k < 6) ? ST_FILL : (k < 22) ? ST_SEARCH : ST_LOCKED;
            bc_exp = (k > 22) ? k - 22 : 0;
            drive(b, 1'b1, 1'b0, 1'b0);
            chk("t5_valid", M_ALL, (k >= 22), 1'b0, 1'b0, st_exp, bc_exp, 0);
            drive(~b, 1'b0, 1'b0, 1'b0);
            chk("t5_idle", M_ALL, (k >= 22), 1'b0, 1'b0, st_exp, bc_exp, 0);
        end

        // clr coincident with an error: err pulses, counters cleared.
        next_bit(b);
        drive(~b, 1'b1, 1'b1, 1'b0);
        chk("t6_clr_err", M_ALL, 1'b1, 1'b1, 1'b0, ST_LOCKED, 0, 0);
        next_bit(b);
        drive(b, 1'b1, 1'b0, 1'b0);
        chk("t6_after_clr", M_ALL, 1'b1, 1'b0, 1'b0, ST_LOCKED, 1, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        #1 force dut.u_err_cnt.r_cnt = 32'hFFFF_FFFF;
        #1 release dut.u_err_cnt.r_cnt;
        next_bit(b);
        drive(~b, 1'b1, 1'b0, 1'b0);
        chk("t6_sat1", M_ALL, 1'b1, 1'b1, 1'b0, ST_LOCKED, 2, 32'hFFFF_FFFF);
        next_bit(b);
        drive(~b, 1'b1, 1'b0, 1'b0);
        chk("t6_sat2", M_ALL, 1'b1, 1'b1, 1'b0, ST_LOCKED, 3, 32'hFFFF_FFFF);

        // Reset while locked, on an erroneous bit.
        next_bit(b);
        drive(~b, 1'b1, 1'b0, 1'b1);
        chk("t6_rst_locked", M_ALL, 1'b0, 1'b0, 1'b0, ST_FILL, 0, 0);
        next_bit(b);
        drive(b, 1'b1, 1'b0, 1'b0);
        chk("t6_post_rst", M_ALL, 1'b0, 1'b0, 1'b0, ST_FILL, 0, 0);

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge sclk);
        #1;
        if (sbq.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations never checked, required 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
